// File: rtl/vga_timing_monitor.sv
// vga_timing_monitor
//   Receive-side checker for 640x480@60 VGA syncs. Samples hs/vs (and
//   optionally de) on the pixel strobe. It measures line and frame lengths,
//   locks onto the nominal H_TOTAL x V_TOTAL timing, and rebuilds pixel
//   coordinates from the syncs alone.
//
//   Optional feature macro: VGA_MON_DE_CHECK_EN
//     defined   -> while locked, de is compared against the rebuilt active
//                  window; each mismatch pulses err and bumps de_err_cnt.
//     undefined -> de is ignored and de_err_cnt reads 0.
//
// Ports
//   CLK100MHZ   in   board clock (only clock)
//   reset       in   synchronous, active-high
//   pix_stb     in   pixel enable, one CLK100MHZ cycle in four
//   hs, vs      in   horizontal / vertical sync, active low
//   de          in   source display enable (only with VGA_MON_DE_CHECK_EN)
//   x, y        out  rebuilt column/row; hold last value outside active
//   act         out  locked and inside the visible window
//   locked      out  timing lock
//   err         out  one-cycle pulse per detected violation
//   frame_stb   out  one-cycle pulse at each frame boundary
//   h_total     out  last measured line length
//   v_total     out  last measured frame length
//   de_err_cnt  out  saturating count of de mismatches
module vga_timing_monitor #(
    parameter int H_TOTAL     = 800,
    parameter int V_TOTAL     = 525,
    parameter int H_START     = 144,
    parameter int V_START     = 34,
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        CLK100MHZ,
    input  logic        reset,
    input  logic        pix_stb,
    input  logic        hs,
    input  logic        vs,
    input  logic        de,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic        act,
    output logic        locked,
    output logic        err,
    output logic        frame_stb,
    output logic [10:0] h_total,
    output logic [10:0] v_total,
    output logic [15:0] de_err_cnt
);
    typedef enum logic [1:0] {S_SEARCH, S_MEASURE, S_LOCKED} state_t;

    localparam logic [10:0] POS_MAX = 11'd2047;
    localparam logic [10:0] H_TOT_L = 11'(H_TOTAL);
    localparam logic [10:0] V_TOT_L = 11'(V_TOTAL);
    localparam logic [10:0] H_LO    = 11'(H_START);
    localparam logic [10:0] H_HI    = 11'(H_START + H_ACTIVE);
    localparam logic [10:0] V_LO    = 11'(V_START);
    localparam logic [10:0] V_HI    = 11'(V_START + V_ACTIVE);
    localparam logic [2:0]  LOCK_N  = 3'(LOCK_FRAMES);

    function automatic logic [10:0] sat_inc(input logic [10:0] v);
        return (v == POS_MAX) ? v : v + 11'd1;
    endfunction

    state_t      state_q, state_d;
    logic [2:0]  good_cnt_q, good_cnt_d;
    logic        hs_q, hs_d, vs_q, vs_d;
    logic        vs_pend_q, vs_pend_d;
    logic        bad_line_q, bad_line_d;   // some line of the current frame was off-length
    logic [10:0] h_pos_q, h_pos_d, v_pos_q, v_pos_d;
    logic [10:0] h_total_q, h_total_d, v_total_q, v_total_d;
    logic [9:0]  x_q, x_d, y_q, y_d;
    logic        act_q, act_d, locked_q, locked_d;
    logic        err_q, err_d, frame_stb_q, frame_stb_d;
    logic        hfe, vfe, line_bad, frame_good;
`ifdef VGA_MON_DE_CHECK_EN
    logic [15:0] de_err_cnt_q, de_err_cnt_d;
`else
    logic        unused_de;
    assign unused_de = de;
`endif

    always_comb begin
        state_d     = state_q;
        good_cnt_d  = good_cnt_q;
        hs_d        = hs_q;
        vs_d        = vs_q;
        vs_pend_d   = vs_pend_q;
        bad_line_d  = bad_line_q;
        h_pos_d     = h_pos_q;
        v_pos_d     = v_pos_q;
        h_total_d   = h_total_q;
        v_total_d   = v_total_q;
        x_d         = x_q;
        y_d         = y_q;
        act_d       = act_q;
        locked_d    = locked_q;
        err_d       = 1'b0;
        frame_stb_d = 1'b0;
        hfe         = 1'b0;
        vfe         = 1'b0;
        line_bad    = 1'b0;
        frame_good  = 1'b0;
`ifdef VGA_MON_DE_CHECK_EN
        de_err_cnt_d = de_err_cnt_q;
`endif
        if (pix_stb) begin
            hs_d = hs;
            vs_d = vs;
            hfe  = hs_q & ~hs;
            vfe  = vs_q & ~vs;

            if (hfe) begin
                h_pos_d    = '0;
                // Saturate so a 2047-tick timeout line reads 2047, not 0.
                h_total_d  = sat_inc(h_pos_q);
                line_bad   = (h_total_d != H_TOT_L);
                v_pos_d    = sat_inc(v_pos_q);
                bad_line_d = bad_line_q | line_bad;
                // Uses the old vs_pend: a vfe in this same sample only arms
                // the boundary for the next hfe.
                if (vs_pend_q) begin
                    v_total_d   = sat_inc(v_pos_q);
                    v_pos_d     = '0;
                    vs_pend_d   = 1'b0;
                    frame_stb_d = 1'b1;
                    frame_good  = (v_total_d == V_TOT_L) && !bad_line_q && !line_bad;
                    bad_line_d  = 1'b0;
                end
            end else begin
                h_pos_d = sat_inc(h_pos_q);
            end
            if (vfe) begin
                vs_pend_d = 1'b1;
            end

            case (state_q)
                S_SEARCH: begin
                    if (frame_stb_d) begin
                        state_d    = S_MEASURE;
                        good_cnt_d = '0;
                    end
                end
                S_MEASURE: begin
                    if (frame_stb_d) begin
                        if (frame_good) begin
                            good_cnt_d = good_cnt_q + 3'd1;
                            if (good_cnt_d == LOCK_N) begin
                                state_d = S_LOCKED;
                            end
                        end else begin
                            good_cnt_d = '0;
                        end
                    end
                end
                S_LOCKED: begin
                    if ((hfe && line_bad) || (frame_stb_d && !frame_good)) begin
                        err_d      = 1'b1;
                        state_d    = S_MEASURE;
                        good_cnt_d = '0;
                    end
                end
                default: begin
                    state_d    = S_SEARCH;
                    good_cnt_d = '0;
                end
            endcase

            // Missing sync: fire once on the step into saturation, then sit
            // in SEARCH until a boundary shows up again.
            if ((h_pos_d == POS_MAX && h_pos_q != POS_MAX) ||
                (v_pos_d == POS_MAX && v_pos_q != POS_MAX)) begin
                err_d      = 1'b1;
                state_d    = S_SEARCH;
                good_cnt_d = '0;
            end

            locked_d = (state_d == S_LOCKED);
            act_d    = locked_d && (h_pos_d >= H_LO) && (h_pos_d < H_HI) &&
                       (v_pos_d >= V_LO) && (v_pos_d < V_HI);
            if (act_d) begin
                x_d = 10'(h_pos_d - H_LO);
                y_d = 10'(v_pos_d - V_LO);
            end

`ifdef VGA_MON_DE_CHECK_EN
            if (state_q == S_LOCKED && de != act_d) begin
                err_d = 1'b1;
                if (de_err_cnt_q != 16'hFFFF) begin
                    de_err_cnt_d = de_err_cnt_q + 16'd1;
                end
            end
`endif
        end
    end

    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            state_q     <= S_SEARCH;
            good_cnt_q  <= '0;
            hs_q        <= 1'b0;
            vs_q        <= 1'b0;
            vs_pend_q   <= 1'b0;
            bad_line_q  <= 1'b0;
            h_pos_q     <= '0;
            v_pos_q     <= '0;
            h_total_q   <= '0;
            v_total_q   <= '0;
            x_q         <= '0;
            y_q         <= '0;
            act_q       <= 1'b0;
            locked_q    <= 1'b0;
            err_q       <= 1'b0;
            frame_stb_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            good_cnt_q  <= good_cnt_d;
            hs_q        <= hs_d;
            vs_q        <= vs_d;
            vs_pend_q   <= vs_pend_d;
            bad_line_q  <= bad_line_d;
            h_pos_q     <= h_pos_d;
            v_pos_q     <= v_pos_d;
            h_total_q   <= h_total_d;
            v_total_q   <= v_total_d;
            x_q         <= x_d;
            y_q         <= y_d;
            act_q       <= act_d;
            locked_q    <= locked_d;
            err_q       <= err_d;
            frame_stb_q <= frame_stb_d;
        end
    end

`ifdef VGA_MON_DE_CHECK_EN
    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            de_err_cnt_q <= '0;
        end else begin
            de_err_cnt_q <= de_err_cnt_d;
        end
    end
    assign de_err_cnt = de_err_cnt_q;
`else
    assign de_err_cnt = '0;
`endif

    assign x         = x_q;
    assign y         = y_q;
    assign act       = act_q;
    assign locked    = locked_q;
    assign err       = err_q;
    assign frame_stb = frame_stb_q;
    assign h_total   = h_total_q;
    assign v_total   = v_total_q;
endmodule

// File: tb/tb_vga_timing_monitor.sv
// Bench for vga_timing_monitor. A reduced 32x14 timing keeps every frame
// short; the generator follows the VGA shape (sync at the start of the line
// and frame, then back porch, then visible area).
module tb_vga_timing_monitor;
    localparam int HT = 32, VT = 14;        // generator totals
    localparam int HSYNC = 4, VSYNC = 2;    // sync widths (low at h/v 0..)
    localparam int HS0 = 8, HA = 16;        // first visible column, width
    localparam int GV0 = 5, VA = 6;         // first visible generator line, height

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1, pix_stb = 1'b0, hs = 1'b1, vs = 1'b1, de = 1'b0;
    logic [9:0]  x, y;
    logic        act, locked, err, frame_stb;
    logic [10:0] h_total, v_total;
    logic [15:0] de_err_cnt;

    vga_timing_monitor #(
        .H_TOTAL(HT), .V_TOTAL(VT), .H_START(HS0), .V_START(GV0 - 1),
        .H_ACTIVE(HA), .V_ACTIVE(VA), .LOCK_FRAMES(2)
    ) dut (
        .CLK100MHZ(clk), .reset(reset), .pix_stb(pix_stb), .hs(hs), .vs(vs),
        .de(de), .x(x), .y(y), .act(act), .locked(locked), .err(err),
        .frame_stb(frame_stb), .h_total(h_total), .v_total(v_total),
        .de_err_cnt(de_err_cnt)
    );

    int checks = 0, errors = 0;
    int gh = 0, gv = 0, line_len = HT;
    bit short_next = 0, hs_force = 0, de_force_low = 0;
    int n_err = 0, n_fstb = 0, n_spur = 0;

    typedef struct packed {
        logic       act;
        logic [9:0] x;
        logic [9:0] y;
    } exp_t;
    exp_t sb[$];

    // One pixel: three idle clocks, then the strobe clock. Returns #1 after
    // the strobe edge so outputs reflect this pixel.
    task automatic pix_tick();
        hs = hs_force ? 1'b1 : (gh >= HSYNC);
        vs = (gv >= VSYNC);
        de = !de_force_low && gh >= HS0 && gh < HS0 + HA && gv >= GV0 && gv < GV0 + VA;
        pix_stb = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (err || frame_stb) n_spur++;
        end
        pix_stb = 1'b1;
        @(posedge clk); #1;
        pix_stb = 1'b0;
        if (err) n_err++;
        if (frame_stb) n_fstb++;
        gh++;
        if (gh >= line_len) begin
            gh = 0;
            line_len = short_next ? HT - 1 : HT;
            short_next = 0;
            gv = (gv + 1) % VT;
        end
    endtask

    task automatic run_to(input int h, input int v);
        for (int i = 0; i < 2 * HT * VT && !(gh == h && gv == v); i++) pix_tick();
    endtask

    task automatic wait_fstb(output bit got);
        got = 0;
        for (int i = 0; i < 2 * HT * VT; i++) begin
            pix_tick();
            if (frame_stb) begin
                got = 1;
                break;
            end
        end
    endtask

    task automatic count_to_lock(output int nf, output bit ok);
        bit got;
        nf = 0;
        ok = 0;
        for (int i = 0; i < 8; i++) begin
            wait_fstb(got);
            if (!got) break;
            nf++;
            if (locked) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (4) pix_tick();
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %0b want 0", locked); end
        checks++; if (act !== 1'b0) begin errors++; $display("FAIL reset_act: got %0b want 0", act); end
        checks++; if (err !== 1'b0 || frame_stb !== 1'b0) begin errors++; $display("FAIL reset_pulses: err %0b fstb %0b want 0 0", err, frame_stb); end
        checks++; if (x !== 10'd0 || y !== 10'd0) begin errors++; $display("FAIL reset_xy: got %0d,%0d want 0,0", x, y); end
        checks++; if (h_total !== 11'd0 || v_total !== 11'd0) begin errors++; $display("FAIL reset_totals: got %0d,%0d want 0,0", h_total, v_total); end
        checks++; if (de_err_cnt !== 16'd0) begin errors++; $display("FAIL reset_de_cnt: got %0d want 0", de_err_cnt); end
        gh = 0; gv = 0; line_len = HT;
        n_err = 0; n_fstb = 0; n_spur = 0;
        reset = 1'b0;
    endtask

    task automatic test_lock();
        int nf; bit ok;
        count_to_lock(nf, ok);
        checks++; if (!ok || nf != 3) begin errors++; $display("FAIL lock_frames: locked %0b after %0d frame_stb want 1 after 3", ok, nf); end
        checks++; if (h_total !== 11'(HT)) begin errors++; $display("FAIL lock_h_total: got %0d want %0d", h_total, HT); end
        checks++; if (v_total !== 11'(VT)) begin errors++; $display("FAIL lock_v_total: got %0d want %0d", v_total, VT); end
        checks++; if (n_err != 0) begin errors++; $display("FAIL lock_no_err: got %0d err pulses want 0", n_err); end
    endtask

    task automatic test_active();
        exp_t e;
        logic [9:0] hx, hy;
        int e0;
        hx = 10'(HA - 1);
        hy = 10'(VA - 1);
        run_to(0, 0);
        e0 = n_err;
        for (int i = 0; i < HT * VT; i++) begin
            e.act = (gh >= HS0 && gh < HS0 + HA && gv >= GV0 && gv < GV0 + VA);
            if (e.act) begin
                hx = 10'(gh - HS0);
                hy = 10'(gv - GV0);
            end
            e.x = hx;
            e.y = hy;
            sb.push_back(e);
            pix_tick();
            e = sb.pop_front();
            checks++; if (act !== e.act) begin errors++; $display("FAIL active_act: got %0b want %0b", act, e.act); end
            checks++; if (x !== e.x) begin errors++; $display("FAIL active_x: got %0d want %0d", x, e.x); end
            checks++; if (y !== e.y) begin errors++; $display("FAIL active_y: got %0d want %0d", y, e.y); end
        end
        checks++; if (locked !== 1'b1 || n_err != e0) begin errors++; $display("FAIL active_lock: locked %0b err %0d want 1 0", locked, n_err - e0); end
    endtask

    task automatic test_short_line();
        int e0, th, tv, nf; bit seen, ok;
        run_to(0, 6);
        short_next = 1;
        e0 = n_err; seen = 0; th = -1; tv = -1;
        for (int i = 0; i < 3 * HT && !seen; i++) begin
            th = gh; tv = gv;
            pix_tick();
            if (err) begin
                seen = 1;
                checks++; if (locked !== 1'b0) begin errors++; $display("FAIL short_locked: got %0b want 0", locked); end
                checks++; if (h_total !== 11'(HT - 1)) begin errors++; $display("FAIL short_h_total: got %0d want %0d", h_total, HT - 1); end
                checks++; if (th != 0 || tv != 8) begin errors++; $display("FAIL short_err_pos: at %0d,%0d want 0,8", th, tv); end
            end
        end
        checks++; if (!seen) begin errors++; $display("FAIL short_err_seen: got 0 want 1"); end
        count_to_lock(nf, ok);
        checks++; if (!ok || nf != 3) begin errors++; $display("FAIL short_relock: locked %0b after %0d frame_stb want 1 after 3", ok, nf); end
        checks++; if (n_err - e0 != 1) begin errors++; $display("FAIL short_err_count: got %0d want 1", n_err - e0); end
    endtask

    task automatic test_hs_timeout();
        int e0, err_at, nf; bit ok;
        run_to(20, 6);
        hs_force = 1; e0 = n_err; err_at = -1;
        for (int i = 1; i <= 2100; i++) begin
            pix_tick();
            if (err && err_at < 0) err_at = i;
        end
        hs_force = 0;
        checks++; if (err_at != 2028) begin errors++; $display("FAIL timeout_at: got tick %0d want 2028", err_at); end
        checks++; if (n_err - e0 != 1) begin errors++; $display("FAIL timeout_err_count: got %0d want 1", n_err - e0); end
        checks++; if (locked !== 1'b0 || act !== 1'b0) begin errors++; $display("FAIL timeout_unlock: locked %0b act %0b want 0 0", locked, act); end
        count_to_lock(nf, ok);
        checks++; if (!ok) begin errors++; $display("FAIL timeout_relock: got locked %0b after %0d frame_stb want 1", ok, nf); end
        checks++; if (n_err - e0 != 1) begin errors++; $display("FAIL timeout_quiet: got %0d err pulses want 1", n_err - e0); end
    endtask

    task automatic test_reset_locked();
        int nf; bit ok;
        run_to(10, 7);
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL rst_pre_locked: got %0b want 1", locked); end
        reset = 1'b1;
        pix_tick();
        reset = 1'b0;
        checks++; if (locked !== 1'b0 || act !== 1'b0 || err !== 1'b0 || frame_stb !== 1'b0) begin errors++; $display("FAIL rst_flags: locked %0b act %0b err %0b fstb %0b want 0", locked, act, err, frame_stb); end
        checks++; if (x !== 10'd0 || y !== 10'd0 || h_total !== 11'd0 || v_total !== 11'd0 || de_err_cnt !== 16'd0) begin errors++; $display("FAIL rst_values: x %0d y %0d ht %0d vt %0d dec %0d want 0", x, y, h_total, v_total, de_err_cnt); end
        count_to_lock(nf, ok);
        checks++; if (!ok || nf != 3) begin errors++; $display("FAIL rst_relock: locked %0b after %0d frame_stb want 1 after 3", ok, nf); end
    endtask

    task automatic test_de();
        int e0, want;
        run_to(0, 7);
        e0 = n_err;
        for (int i = 0; i < HT; i++) begin
            de_force_low = (gh >= 10 && gh < 20);
            pix_tick();
        end
        de_force_low = 0;
`ifdef VGA_MON_DE_CHECK_EN
        want = 10;
`else
        want = 0;
`endif
        checks++; if (n_err - e0 != want) begin errors++; $display("FAIL de_err_pulses: got %0d want %0d", n_err - e0, want); end
        checks++; if (de_err_cnt !== 16'(want)) begin errors++; $display("FAIL de_err_cnt: got %0d want %0d", de_err_cnt, want); end
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL de_locked: got %0b want 1", locked); end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_active();
        test_short_line();
        test_hs_timeout();
        test_reset_locked();
        test_de();
        checks++; if (n_spur != 0) begin errors++; $display("FAIL pulse_width: got %0d off-strobe pulses want 0", n_spur); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
